// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues sequential word fetches, buffers in-order
// responses in a small FIFO and hands {instr, instr_pc} to decode. Redirects
// from execute flush the buffer and discard responses still in flight.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_W = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] fifoCount_q, fifoCount_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [31:0]      fifoInstr_q [FIFO_DEPTH];
    logic [31:0]      fifoPc_q    [FIFO_DEPTH];

    logic             reqFire;
    logic             respTaken;
    logic             push;
    logic             pop;
    logic [CNT_W:0]   creditSum;

    assign instr_valid   = (fifoCount_q != '0);
    assign instr         = instr_valid ? fifoInstr_q[rdPtr_q] : 32'h0;
    assign instr_pc      = instr_valid ? fifoPc_q[rdPtr_q]    : 32'h0;
    assign imem_req_addr = pc_q;
    assign creditSum     = {1'b0, outstanding_q} + {1'b0, fifoCount_q};

    // Next-state logic: request credit, outstanding count, FIFO pointers and redirect handling.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        outstanding_d  = outstanding_q;
        fifoCount_d    = fifoCount_q;
        rdPtr_d        = rdPtr_q;
        wrPtr_d        = wrPtr_q;
        imem_req_valid = 1'b0;
        push           = 1'b0;
        respTaken      = imem_resp_valid && (outstanding_q != '0);
        pop            = instr_valid && instr_ready;

        case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                imem_req_valid = (creditSum < DEPTH_W);
                push           = respTaken && !redirect_valid;
            end
            DRAIN: begin
                imem_req_valid = 1'b0;
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        reqFire = imem_req_valid && imem_req_ready;

        if (reqFire) begin
            pc_d = pc_q + 32'd4;
        end

        case ({reqFire, respTaken})
            2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase

        if (redirect_valid) begin
            fifoCount_d = '0;
            rdPtr_d     = '0;
            wrPtr_d     = '0;
        end else begin
            if (push) begin
                wrPtr_d = wrPtr_q + PTR_W'(1);
            end
            if (pop) begin
                rdPtr_d = rdPtr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifoCount_d = fifoCount_q + CNT_W'(1);
                2'b01:   fifoCount_d = fifoCount_q - CNT_W'(1);
                default: fifoCount_d = fifoCount_q;
            endcase
        end

        if (redirect_valid) begin
            pc_d = redirect_pc & ~32'd3;
            if (state_q != BOOT) begin
                state_d = (outstanding_d != '0) ? DRAIN : FETCH;
            end
        end else if (state_q == DRAIN && outstanding_d == '0) begin
            state_d = FETCH;
        end
    end

    // Control registers, cleared asynchronously while reset is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            fifoCount_q   <= '0;
            rdPtr_q       <= '0;
            wrPtr_q       <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            fifoCount_q   <= fifoCount_d;
            rdPtr_q       <= rdPtr_d;
            wrPtr_q       <= wrPtr_d;
        end
    end

    // FIFO storage; contents only matter while the count marks them valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoInstr_q[wrPtr_q] <= imem_resp_data;
            fifoPc_q[wrPtr_q]    <= pc_q - {outstanding_q, 2'b00} + {fifoCount_q, 2'b00} - {fifoCount_q, 2'b00};
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a queue-based model of requests in
// flight and buffered instructions is compared against the DUT every cycle,
// with a few literal expectations on fetch and handshake addresses.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    instr_fetch_unit #(
        .RESET_PC  (RESET_PC),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    typedef struct {
        logic [31:0] pc;
        bit          stale;
    } flight_t;

    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
    } entry_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } memreq_t;

    int          vecCount  = 0;
    int          missCount = 0;
    int          cyc       = 0;
    int          memLat    = 1;

    logic [31:0] mPc;
    bit          mBoot;
    flight_t     inflight[$];
    entry_t      buffer[$];
    memreq_t     memQ[$];
    logic [31:0] acceptLog[$];
    logic [31:0] popLog[$];

    flight_t     fTmp;
    entry_t      eTmp;
    memreq_t     mTmp;
    bit          expReq;
    bit          expInstr;
    bit          anyStale;
    bit          accNow;
    bit          popNow;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memData(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
    endfunction

    function automatic logic [31:0] acceptAt(input int i);
        if (i >= 0 && i < acceptLog.size()) return acceptLog[i];
        return 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] popAt(input int i);
        if (i >= 0 && i < popLog.size()) return popLog[i];
        return 32'hxxxx_xxxx;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One clock edge; afterwards the memory presents its next due response.
    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        if (reset && memQ.size() > 0 && memQ[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = memData(memQ[0].addr);
            void'(memQ.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
        end
    endtask

    task automatic applyStimulus(input bit memRdy, input bit decRdy, input bit redir,
                                 input logic [31:0] rpc, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            imem_req_ready = memRdy;
            instr_ready    = decRdy;
            redirect_valid = redir;
            redirect_pc    = rpc;
            tick();
        end
        redirect_valid = 1'b0;
    endtask

    // Model and compare: mid-cycle, check DUT outputs against the model, then
    // advance the model and the memory across the coming edge.
    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
            checkOutput("rst_req_addr", imem_req_addr, RESET_PC);
            checkOutput("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
            checkOutput("rst_instr", instr, 32'h0);
            checkOutput("rst_instr_pc", instr_pc, 32'h0);
            mPc   = RESET_PC;
            mBoot = 1'b1;
            inflight.delete();
            buffer.delete();
            memQ.delete();
            acceptLog.delete();
            popLog.delete();
        end else begin
            anyStale = 1'b0;
            foreach (inflight[i]) if (inflight[i].stale) anyStale = 1'b1;
            expReq   = !mBoot && !anyStale && (inflight.size() + buffer.size() < DEPTH);
            expInstr = (buffer.size() != 0);

            checkOutput("req_valid", {31'b0, imem_req_valid}, {31'b0, expReq});
            if (expReq) checkOutput("req_addr", imem_req_addr, mPc);
            checkOutput("instr_valid", {31'b0, instr_valid}, {31'b0, expInstr});
            if (expInstr) begin
                checkOutput("instr", instr, buffer[0].data);
                checkOutput("instr_pc", instr_pc, buffer[0].pc);
                checkOutput("instr_vs_mem", instr, memData(buffer[0].pc));
            end

            if (imem_req_valid && imem_req_ready) begin
                mTmp.addr = imem_req_addr;
                mTmp.due  = cyc + memLat;
                memQ.push_back(mTmp);
            end

            accNow = expReq && imem_req_ready;
            popNow = expInstr && instr_ready;
            if (popNow) begin
                popLog.push_back(buffer[0].pc);
                void'(buffer.pop_front());
            end
            if (imem_resp_valid && inflight.size() > 0) begin
                fTmp = inflight.pop_front();
                if (!fTmp.stale && !redirect_valid) begin
                    eTmp.data = imem_resp_data;
                    eTmp.pc   = fTmp.pc;
                    buffer.push_back(eTmp);
                end
            end
            if (accNow) begin
                acceptLog.push_back(mPc);
                fTmp.pc    = mPc;
                fTmp.stale = redirect_valid;
                inflight.push_back(fTmp);
                mPc = mPc + 32'd4;
            end
            if (redirect_valid) begin
                buffer.delete();
                foreach (inflight[i]) inflight[i].stale = 1'b1;
                mPc = redirect_pc & ~32'd3;
            end
            mBoot = 1'b0;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        int pm;
        int am;
        int idx;
        bit found;

        reset           = 1'b1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        instr_ready     = 1'b0;
        #2 reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 3);

        // Sequential fetch, latency 1, always ready
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 14);
        checkOutput("t1_acc0", acceptAt(0), 32'h0);
        checkOutput("t1_acc1", acceptAt(1), 32'h4);
        checkOutput("t1_acc2", acceptAt(2), 32'h8);
        checkOutput("t1_pop0", popAt(0), 32'h0);
        checkOutput("t1_pop1", popAt(1), 32'h4);
        checkOutput("t1_pop2", popAt(2), 32'h8);

        // Memory ready toggling: request must hold until accepted
        for (int i = 0; i < 12; i++) applyStimulus((i % 3) != 0, 1'b1, 1'b0, 32'h0, 1);

        // Decode stall for 10 cycles
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 10);
        checkOutput("t2_req_idle", {31'b0, imem_req_valid}, 32'h0);
        checkOutput("t2_buffered", {31'b0, instr_valid}, 32'h1);
        pm = popLog.size();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 14);
        for (int k = 0; k < 5; k++)
            checkOutput("t2_no_loss", popAt(pm + k), popAt(pm + k - 1) + 32'd4);

        // Latency 3, redirect with two in flight
        reset = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 2);
        memLat = 3;
        reset  = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 3);
        checkOutput("t3_inflight", acceptLog.size(), 32'd2);
        am = acceptLog.size();
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h100, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 14);
        checkOutput("t3_first_acc", acceptAt(am), 32'h100);
        checkOutput("t3_first_pop", popAt(0), 32'h100);

        // Back-to-back redirects: newest target wins
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h300, 1);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h340, 1);
        am = acceptLog.size();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 12);
        checkOutput("t3b_newest", acceptAt(am), 32'h340);

        // Redirect coinciding with response and pop, latency 1
        reset = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 2);
        memLat = 1;
        reset  = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 8);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (imem_resp_valid && instr_valid) found = 1'b1;
            else applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1);
        end
        checkOutput("t4_aligned", {31'b0, found}, 32'h1);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h203, 1);
        checkOutput("t4_flushed", {31'b0, instr_valid}, 32'h0);
        am = acceptLog.size();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 8);
        checkOutput("t4_next_addr", acceptAt(am), 32'h200);

        // PC wrap at the top of the address space
        am = acceptLog.size();
        applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 12);
        idx = -1;
        for (int i = am; i < acceptLog.size(); i++)
            if (idx < 0 && acceptLog[i] == 32'hFFFF_FFFC) idx = i;
        checkOutput("t5_reached_top", {31'b0, idx >= 0}, 32'h1);
        if (idx >= 0) checkOutput("t5_wrap", acceptAt(idx + 1), 32'h0);

        // Reset asserted during drain
        reset = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 2);
        memLat = 3;
        reset  = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 3);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h500, 1);
        reset = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 2);
        checkOutput("t6_req_reset", {31'b0, imem_req_valid}, 32'h0);
        checkOutput("t6_addr_reset", imem_req_addr, RESET_PC);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 8);
        checkOutput("t6_first_acc", acceptAt(0), RESET_PC);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
